// File: rtl/rat_uart_tx_port_if.sv
// RAT MCU port-mapped I/O bus as seen by a peripheral.
// The MCU (master) drives the port address, data and strobe.
// The peripheral (slave) returns a status byte and its select line to the IN_PORT mux.
interface rat_uart_tx_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       IN_SEL;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_DATA,
    input  IN_SEL
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_DATA,
    output IN_SEL
  );
endinterface

// File: rtl/rat_uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for the RAT MCU.
// Bytes written to DATA_PORT_ID are queued in an 8-deep FIFO and sent LSB first.
// The status port returns {count, ovf, busy, full, empty}.
// Writing a 1 in bit 0 of the status port clears the sticky overflow flag.
// INTR pulses for one cycle when the line goes idle after the last queued byte.
module rat_uart_tx_port #(
  parameter int unsigned CLK_DIV        = 868,
  parameter logic [7:0]  DATA_PORT_ID   = 8'h40,
  parameter logic [7:0]  STATUS_PORT_ID = 8'h41
) (
  input  logic                 clk,
  input  logic                 RESET,
  rat_uart_tx_port_if.slave    io,
  output logic                 TX,
  output logic                 INTR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        intr_q;

  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  fifo_count;
  logic        ovf;

  logic        fifo_empty;
  logic        fifo_full;
  logic        baud_end;
  logic        push_req;
  logic        clr_req;
  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic [7:0]  status;

  assign fifo_empty = (fifo_count == 4'd0);
  assign fifo_full  = (fifo_count == 4'd8);
  assign baud_end   = (baud_cnt == BAUD_LAST);

  assign push_req = io.IO_STRB && (io.PORT_ID == DATA_PORT_ID);
  assign clr_req  = io.IO_STRB && (io.PORT_ID == STATUS_PORT_ID) && io.OUT_PORT[0];

  // A byte leaves the FIFO when an idle transmitter sees data, or when a stop bit
  // ends with more data waiting, so back-to-back frames have no idle gap.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

  // A full FIFO still accepts a byte if a slot is freed on the same edge.
  assign push_ok = push_req && (!fifo_full || pop);
  assign ovf_set = push_req && fifo_full && !pop;

  assign status     = {fifo_count, ovf, (state != ST_IDLE), fifo_full, fifo_empty};
  assign io.IN_SEL  = (io.PORT_ID == STATUS_PORT_ID);
  assign io.IN_DATA = io.IN_SEL ? status : 8'h00;
  assign INTR       = intr_q;

  // FIFO storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= io.OUT_PORT;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      fifo_count <= 4'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      fifo_count <= fifo_count + {3'd0, push_ok} - {3'd0, pop};
    end
  end

  // Sticky overflow flag; a new overflow beats a clear in the same cycle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (clr_req) begin
      ovf <= 1'b0;
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, each CLK_DIV cycles long.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      intr_q    <= 1'b0;
    end else begin
      intr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          baud_cnt <= 16'd0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              state     <= ST_START;
            end else begin
              state  <= ST_IDLE;
              intr_q <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  // Line level is decoded from the registered state, so reset forces it high at once.
  always_comb begin
    TX = 1'b1;
    case (state)
      ST_START: TX = 1'b0;
      ST_DATA:  TX = shift_reg[0];
      default:  TX = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Testbench for rat_uart_tx_port.
// A frame-level reference model predicts line level, INTR and status every cycle.
module tb_rat_uart_tx_port;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic RESET;
  logic TX;
  logic INTR;

  rat_uart_tx_port_if io ();

  rat_uart_tx_port #(
    .CLK_DIV        (DIV),
    .DATA_PORT_ID   (8'h40),
    .STATUS_PORT_ID (8'h41)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .io    (io.slave),
    .TX    (TX),
    .INTR  (INTR)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [7:0] byte_q [$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_ovf;
  bit         m_intr;

  task automatic modelReset();
    byte_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_byte   = 8'h00;
    m_ovf    = 1'b0;
    m_intr   = 1'b0;
  endtask

  function automatic logic expTx();
    if (!m_active)        return 1'b1;
    if (m_t < DIV)        return 1'b0;
    if (m_t < 9 * DIV)    return m_byte[(m_t - DIV) / DIV];
    return 1'b1;
  endfunction

  function automatic logic [7:0] expStatus();
    logic [7:0] s;
    s[7:4] = 4'(byte_q.size());
    s[3]   = m_ovf;
    s[2]   = m_active;
    s[1]   = (byte_q.size() == 8);
    s[0]   = (byte_q.size() == 0);
    return s;
  endfunction

  // Advance the model across one rising edge using the inputs that were stable before it.
  task automatic modelEdge();
    bit at_end;
    bit pop;
    bit push_req;
    bit clr;
    bit set;
    if (RESET) begin
      modelReset();
      return;
    end
    at_end   = m_active && (m_t == FRAME - 1);
    pop      = (byte_q.size() > 0) && (!m_active || at_end);
    push_req = io.IO_STRB && (io.PORT_ID == 8'h40);
    clr      = io.IO_STRB && (io.PORT_ID == 8'h41) && io.OUT_PORT[0];
    set      = push_req && (byte_q.size() == 8) && !pop;
    m_intr   = 1'b0;
    if (pop) begin
      m_byte   = byte_q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else if (at_end) begin
      m_active = 1'b0;
      m_intr   = 1'b1;
    end else if (m_active) begin
      m_t++;
    end
    if (push_req && !set) byte_q.push_back(io.OUT_PORT);
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic sel;
    sel = (io.PORT_ID == 8'h41);
    checkVal("tx",      {7'd0, TX},        {7'd0, expTx()});
    checkVal("intr",    {7'd0, INTR},      {7'd0, m_intr});
    checkVal("in_sel",  {7'd0, io.IN_SEL}, {7'd0, sel});
    checkVal("in_data", io.IN_DATA,        sel ? expStatus() : 8'h00);
  endtask

  // One bus cycle: drive after the falling edge, check, then step the model at the rising edge.
  task automatic busCycle(input logic [7:0] port, input logic [7:0] data, input bit strb,
                          input bit has_exp, input string tag, input logic [7:0] exp);
    io.PORT_ID  = port;
    io.OUT_PORT = data;
    io.IO_STRB  = strb;
    #1;
    checkOutput();
    if (has_exp) checkVal(tag, io.IN_DATA, exp);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data, input bit strb);
    busCycle(port, data, strb, 1'b0, "", 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h41, 8'h00, 1'b0);
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int r;
    checks      = 0;
    errors      = 0;
    io.PORT_ID  = 8'h41;
    io.OUT_PORT = 8'h00;
    io.IO_STRB  = 1'b0;
    RESET       = 1'b1;
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkVal("reset_status", io.IN_DATA, 8'h01);
    checkVal("reset_tx",     {7'd0, TX},   8'h01);
    checkVal("reset_intr",   {7'd0, INTR}, 8'h00);
    RESET = 1'b0;
    @(negedge clk);

    // Single byte
    $display("[TB] single byte 8'hA5");
    applyStimulus(8'h40, 8'hA5, 1'b1);
    idle(FRAME + 6);

    // Back-to-back frames
    $display("[TB] back-to-back 8'h00 8'hFF");
    applyStimulus(8'h40, 8'h00, 1'b1);
    applyStimulus(8'h40, 8'hFF, 1'b1);
    idle(2 * FRAME + 6);

    // Reset mid-frame while the line is low
    $display("[TB] reset mid-frame");
    applyStimulus(8'h40, 8'h00, 1'b1);
    idle(15);
    #2;
    RESET = 1'b1;
    modelReset();
    #1;
    checkVal("midreset_tx",     {7'd0, TX},   8'h01);
    checkVal("midreset_status", io.IN_DATA,   8'h01);
    checkVal("midreset_intr",   {7'd0, INTR}, 8'h00);
    @(negedge clk);
    idle(2);
    RESET = 1'b0;
    idle(FRAME + 6);

    // Fill and overflow
    $display("[TB] fill and overflow");
    for (int i = 0; i < 10; i++) applyStimulus(8'h40, 8'($urandom), 1'b1);
    busCycle(8'h41, 8'h00, 1'b0, 1'b1, "fill_status", 8'h8E);

    // Overflow clear: bit0 clear leaves the flag, bit0 set clears it
    applyStimulus(8'h41, 8'h00, 1'b1);
    busCycle(8'h41, 8'h01, 1'b1, 1'b1, "ovf_kept", 8'h8E);
    busCycle(8'h41, 8'h00, 1'b0, 1'b1, "ovf_cleared", 8'h86);

    // Push into a full FIFO on the same edge as the stop-bit pop
    $display("[TB] full with simultaneous pop");
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_active && (m_t == FRAME - 1)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(8'h41, 8'h00, 1'b0);
    end
    checkVal("stop_edge_found", {7'd0, found}, 8'h01);
    applyStimulus(8'h40, 8'h3C, 1'b1);
    busCycle(8'h41, 8'h00, 1'b0, 1'b1, "full_pop_status", 8'h86);
    idle(9 * FRAME + 10);

    // Randomised traffic mixed with status writes and reads of other ports
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)       applyStimulus(8'h40, 8'($urandom), 1'b1);
      else if (r == 3) applyStimulus(8'h41, 8'($urandom), 1'b1);
      else if (r == 4) applyStimulus(8'h42, 8'($urandom), 1'b1);
      else             applyStimulus(8'($urandom), 8'($urandom), 1'b0);
    end
    idle(9 * FRAME + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
